// File: rtl/ws2812_pixel_serializer.sv
// Serializes 24-bit GRB pixels MSB first into databit/command pairs for the WS2812 bit encoder.
// A frame ends with a latch gap of LATCH_CYCLES idle clocks, and frame_done pulses when that gap has elapsed.
module ws2812_pixel_serializer #(
  parameter int BIT_CYCLES   = 3,
  parameter int PIXEL_BITS   = 24,
  parameter int LATCH_CYCLES = 200
) (
  input  logic                  clk_3p33mhz,
  input  logic                  rst_n,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  input  logic                  pixel_valid,
  input  logic                  pixel_last,
  output logic                  pixel_ready,
  output logic                  databit,
  output logic [1:0]            command,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun,
  output logic [1:0]            fsm_state
);

  // Stream handshake: a pixel transfers on any posedge where pixel_valid && pixel_ready;
  // pixel_valid, pixel_data and pixel_last must stay stable until that transfer.

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = $clog2(PIXEL_BITS);
  localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_TX   = 2'b01;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_PRE  = CNT_W'(BIT_CYCLES - 2);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PIXEL_BITS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  logic [1:0]            state;
  logic [PIXEL_BITS-1:0] shift_reg;
  logic                  last_flag;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [LAT_W-1:0]      latch_cnt;

  logic accept;
  logic bit_wrap;

  assign accept    = pixel_valid & pixel_ready;
  assign bit_wrap  = (bit_cnt == BIT_LAST);
  assign fsm_state = state;

  always_ff @(posedge clk_3p33mhz) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      last_flag   <= 1'b0;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      latch_cnt   <= '0;
      pixel_ready <= 1'b0;
      databit     <= 1'b0;
      command     <= CMD_IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          pixel_ready <= 1'b1;
          databit     <= 1'b0;
          command     <= CMD_IDLE;
          if (accept) begin
            shift_reg   <= pixel_data;
            last_flag   <= pixel_last;
            databit     <= pixel_data[PIXEL_BITS-1];
            command     <= CMD_TX;
            busy        <= 1'b1;
            bit_cnt     <= '0;
            bit_idx     <= IDX_TOP;
            pixel_ready <= 1'b0;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Ready opens for exactly the final clock of the final bit, unless this pixel closes the frame.
          pixel_ready <= (bit_cnt == BIT_PRE) && (bit_idx == '0) && !last_flag;
          if (!bit_wrap) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            bit_cnt <= '0;
            if (bit_idx != '0) begin
              bit_idx   <= bit_idx - 1'b1;
              databit   <= shift_reg[PIXEL_BITS-2];
              shift_reg <= shift_reg << 1;
            end else if (accept) begin
              shift_reg <= pixel_data;
              last_flag <= pixel_last;
              databit   <= pixel_data[PIXEL_BITS-1];
              command   <= CMD_TX;
              bit_idx   <= IDX_TOP;
            end else begin
              command   <= CMD_IDLE;
              databit   <= 1'b0;
              latch_cnt <= '0;
              underrun  <= !last_flag;
              state     <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          pixel_ready <= 1'b0;
          command     <= CMD_IDLE;
          databit     <= 1'b0;
          if (latch_cnt == LAT_LAST) begin
            frame_done  <= 1'b1;
            busy        <= 1'b0;
            pixel_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          pixel_ready <= 1'b0;
          command     <= CMD_IDLE;
          databit     <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Directed bench for ws2812_pixel_serializer covering reset, single-pixel and multi-pixel frames, underrun, mid-frame reset and held-valid behaviour.
// Expected bit streams, ready positions and latch timing are derived from the pixel values and the fixed 3/24/200 timing.
module tb_ws2812_pixel_serializer;

  logic        clk_3p33mhz = 1'b0;
  logic        rst_n;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_last;
  logic        pixel_ready;
  logic        databit;
  logic [1:0]  command;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] pix_tab [3];

  ws2812_pixel_serializer #(.BIT_CYCLES(3), .PIXEL_BITS(24), .LATCH_CYCLES(200)) dut (
    .clk_3p33mhz (clk_3p33mhz),
    .rst_n       (rst_n),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_last  (pixel_last),
    .pixel_ready (pixel_ready),
    .databit     (databit),
    .command     (command),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .fsm_state   (fsm_state)
  );

  always #5 clk_3p33mhz = ~clk_3p33mhz;

  task automatic tick();
    @(posedge clk_3p33mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!pixel_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, 32'(pixel_ready), 32'd1);
  endtask

  // Entered on the first cycle after the last TX clock.
  task automatic latch_check(input string tag, input logic exp_underrun);
    int cmd_bad = 0, fd_early = 0, busy_bad = 0, ur_extra = 0;
    check({tag, "_underrun"}, 32'(underrun), 32'(exp_underrun));
    for (int i = 0; i < 200; i++) begin
      if (command != 2'b00) cmd_bad++;
      if (frame_done) fd_early++;
      if (!busy) busy_bad++;
      if (underrun && i > 0) ur_extra++;
      tick();
    end
    check({tag, "_latch_cmd"}, 32'(cmd_bad), 32'd0);
    check({tag, "_latch_fd_early"}, 32'(fd_early), 32'd0);
    check({tag, "_latch_busy"}, 32'(busy_bad), 32'd0);
    check({tag, "_latch_underrun_extra"}, 32'(ur_extra), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_frame_done_pulse"}, 32'(frame_done), 32'd0);
  endtask

  // Sends n pixels from pix_tab; no_last leaves pixel_last clear on the final pixel.
  task automatic run_frame(input string tag, input int n, input bit toggle, input bit no_last);
    int tx_bad = 0, bit_bad = 0, busy_bad = 0, rdy_seen = 0, rdy_bad = 0;
    int nxt = 1;
    logic acc;
    logic exp_bit;
    logic [23:0] cur;
    bit rdy_ok;
    pixel_data  = pix_tab[0];
    pixel_last  = (n == 1) && !no_last;
    pixel_valid = 1'b1;
    wait_ready(tag);
    tick();
    if (n > 1) begin
      pixel_data  = pix_tab[1];
      pixel_last  = (n == 2) && !no_last;
      pixel_valid = !toggle;
    end else begin
      pixel_valid = 1'b0;
      pixel_last  = 1'b0;
    end
    for (int c = 0; c < n * 72; c++) begin
      cur = pix_tab[c / 72];
      exp_bit = cur[23 - (c % 72) / 3];
      if (command != 2'b01) tx_bad++;
      if (databit !== exp_bit) bit_bad++;
      if (!busy) busy_bad++;
      rdy_ok = ((c % 72) == 71) && ((c / 72) < n - 1 || no_last);
      if (pixel_ready) begin
        rdy_seen++;
        if (!rdy_ok) rdy_bad++;
      end
      if (toggle && nxt < n) pixel_valid = ((c % 72) >= 10) ? 1'b1 : 1'(c % 2);
      acc = pixel_valid && pixel_ready;
      tick();
      if (acc) begin
        nxt++;
        if (nxt < n) begin
          pixel_data  = pix_tab[nxt];
          pixel_last  = (nxt == n - 1) && !no_last;
          pixel_valid = !toggle;
        end else begin
          pixel_valid = 1'b0;
          pixel_last  = 1'b0;
        end
      end
    end
    check({tag, "_tx_cmd"}, 32'(tx_bad), 32'd0);
    check({tag, "_bits"}, 32'(bit_bad), 32'd0);
    check({tag, "_busy_tx"}, 32'(busy_bad), 32'd0);
    check({tag, "_ready_count"}, 32'(rdy_seen), 32'(n - 1 + (no_last ? 1 : 0)));
    check({tag, "_ready_pos"}, 32'(rdy_bad), 32'd0);
    check({tag, "_accepted"}, 32'(nxt), 32'(n));
    check({tag, "_cmd_after"}, 32'(command), 32'd0);
    check({tag, "_databit_after"}, 32'(databit), 32'd0);
    latch_check(tag, no_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    rst_n       = 1'b0;
    pixel_valid = 1'b1;
    pixel_last  = 1'b1;
    pixel_data  = 24'hA50FC3;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", 32'(pixel_ready), 32'd0);
      check("rst_cmd", 32'(command), 32'd0);
      check("rst_databit", 32'(databit), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick();
    end
    rst_n = 1'b1;

    pix_tab[0] = 24'hA50FC3;
    run_frame("single", 1, 1'b0, 1'b0);

    pix_tab[0] = 24'h123456;
    pix_tab[1] = 24'hFEDCBA;
    pix_tab[2] = 24'h80_01_7E;
    run_frame("frame3", 3, 1'b0, 1'b0);

    pix_tab[0] = 24'hFFFFFF;
    run_frame("underrun", 1, 1'b0, 1'b1);

    pixel_data  = 24'h5A5A5A;
    pixel_last  = 1'b1;
    pixel_valid = 1'b1;
    wait_ready("midrst");
    tick();
    pixel_valid = 1'b0;
    repeat (40) tick();
    check("midrst_tx_before", 32'(command), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_cmd", 32'(command), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_databit", 32'(databit), 32'd0);
    tick();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 300; i++) begin
      if (frame_done || underrun || command != 2'b00) stray++;
      tick();
    end
    check("midrst_no_pulses", 32'(stray), 32'd0);
    pix_tab[0] = 24'h3C965A;
    run_frame("after_rst", 1, 1'b0, 1'b0);

    pix_tab[0] = 24'h00FF00;
    pix_tab[1] = 24'hC0FFEE;
    run_frame("toggle", 2, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
